mem_port_arbiter: RTL and testbench

//  Shares the single unified memory port between instruction fetch (IF) and

---
 rtl/mem_port_arbiter_if.sv | 46 ++++
 rtl/mem_port_arbiter.sv | 135 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Unified memory port bundle: IF/MEM requester side plus memory bus side.
// The arbiter takes the slave view; the environment drives the master view.
interface mem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_done;
    logic [DW-1:0] if_rdata;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_done;
    logic [DW-1:0] mem_rdata;
    logic          bus_req;
    logic          bus_we;
    logic [AW-1:0] bus_addr;
    logic [DW-1:0] bus_wdata;
    logic [DW-1:0] bus_rdata;
    logic          bus_ready;
    logic          sel;
    logic          if_stall;
    logic          mem_stall;

    modport master (
        output if_req, if_addr,
        output mem_req, mem_we, mem_addr, mem_wdata,
        output bus_rdata, bus_ready,
        input  if_done, if_rdata,
        input  mem_done, mem_rdata,
        input  bus_req, bus_we, bus_addr, bus_wdata,
        input  sel, if_stall, mem_stall
    );

    modport slave (
        input  if_req, if_addr,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        input  bus_rdata, bus_ready,
        output if_done, if_rdata,
        output mem_done, mem_rdata,
        output bus_req, bus_we, bus_addr, bus_wdata,
        output sel, if_stall, mem_stall
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch (IF) and data (MEM); MEM has priority,
// a starvation counter forces an IF grant after MAX_WAIT back-to-back MEM grants.
module mem_port_arbiter #(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic clk,
    input  logic clrn,
    mem_port_arbiter_if.slave p
);
    localparam int SW = $clog2(MAX_WAIT + 1);
    localparam logic [SW-1:0] MAX_W = SW'(MAX_WAIT);

    typedef enum logic [1:0] {
        IDLE,
        BUSY_IF,
        BUSY_MEM
    } state_t;

    state_t        state_q, state_d;
    logic          bus_req_q, bus_req_d;
    logic          bus_we_q, bus_we_d;
    logic          sel_q, sel_d;
    logic          if_done_q, if_done_d;
    logic          mem_done_q, mem_done_d;
    logic [AW-1:0] bus_addr_q, bus_addr_d;
    logic [DW-1:0] bus_wdata_q, bus_wdata_d;
    logic [DW-1:0] if_rdata_q, if_rdata_d;
    logic [DW-1:0] mem_rdata_q, mem_rdata_d;
    logic [SW-1:0] starve_q, starve_d;
    logic          arb_ok;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q     <= IDLE;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            sel_q       <= 1'b0;
            if_done_q   <= 1'b0;
            mem_done_q  <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
            starve_q    <= '0;
        end else begin
            state_q     <= state_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            sel_q       <= sel_d;
            if_done_q   <= if_done_d;
            mem_done_q  <= mem_done_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
            starve_q    <= starve_d;
        end
    end

    // The done cycle is the single gap between transactions: no grant in it.
    assign arb_ok = ~if_done_q & ~mem_done_q;

    always_comb begin
        state_d     = state_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        sel_d       = sel_q;
        if_done_d   = 1'b0;
        mem_done_d  = 1'b0;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;
        starve_d    = starve_q;
        unique case (state_q)
            IDLE: begin
                if (arb_ok && p.mem_req &&
                    (!p.if_req || starve_q < MAX_W)) begin
                    state_d     = BUSY_MEM;
                    bus_req_d   = 1'b1;
                    sel_d       = 1'b1;
                    bus_we_d    = p.mem_we;
                    bus_addr_d  = p.mem_addr;
                    bus_wdata_d = p.mem_wdata;
                    if (!p.if_req)
                        starve_d = '0;
                    else if (starve_q != MAX_W)
                        starve_d = starve_q + SW'(1);
                end else if (arb_ok && p.if_req) begin
                    state_d    = BUSY_IF;
                    bus_req_d  = 1'b1;
                    sel_d      = 1'b0;
                    bus_we_d   = 1'b0;
                    bus_addr_d = p.if_addr;
                    starve_d   = '0;
                end else if (!p.if_req) begin
                    starve_d = '0;
                end
            end
            BUSY_IF: begin
                if (p.bus_ready) begin
                    state_d    = IDLE;
                    bus_req_d  = 1'b0;
                    bus_we_d   = 1'b0;
                    if_done_d  = 1'b1;
                    if_rdata_d = p.bus_rdata;
                end
            end
            BUSY_MEM: begin
                if (p.bus_ready) begin
                    state_d     = IDLE;
                    bus_req_d   = 1'b0;
                    bus_we_d    = 1'b0;
                    mem_done_d  = 1'b1;
                    mem_rdata_d = p.bus_rdata;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign p.bus_req   = bus_req_q;
    assign p.bus_we    = bus_we_q;
    assign p.sel       = sel_q;
    assign p.bus_addr  = bus_addr_q;
    assign p.bus_wdata = bus_wdata_q;
    assign p.if_done   = if_done_q;
    assign p.mem_done  = mem_done_q;
    assign p.if_rdata  = if_rdata_q;
    assign p.mem_rdata = mem_rdata_q;
    assign p.if_stall  = p.if_req & ~if_done_q;
    assign p.mem_stall = p.mem_req & ~mem_done_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: single fetch, priority, starvation,
// wait states, dropped request and mid-transaction reset.
module tb_mem_port_arbiter;
    logic clk;
    logic clrn;
    int   n_chk;
    int   n_fail;

    mem_port_arbiter_if #(.AW(32), .DW(32)) bif ();

    mem_port_arbiter #(.AW(32), .DW(32), .MAX_WAIT(4)) dut (
        .clk  (clk),
        .clrn (clrn),
        .p    (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic idle_inputs();
        bif.if_req    = 1'b0;
        bif.if_addr   = '0;
        bif.mem_req   = 1'b0;
        bif.mem_we    = 1'b0;
        bif.mem_addr  = '0;
        bif.mem_wdata = '0;
        bif.bus_rdata = '0;
        bif.bus_ready = 1'b0;
    endtask

    bit exp_sel [10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        n_chk  = 0;
        n_fail = 0;
        idle_inputs();
        clrn = 1'b0;
        #3;
        chk("rst_bus_req", bif.bus_req, 0);
        chk("rst_outs", {bif.bus_we, bif.sel, bif.if_done, bif.mem_done}, 0);
        chk("rst_data", {bif.bus_addr, bif.bus_wdata}, 0);
        chk("rst_rdata", {bif.if_rdata, bif.mem_rdata}, 0);
        step(1);
        clrn = 1'b1;
        step(1);

        // 1: single fetch
        bif.if_req  = 1'b1;
        bif.if_addr = 32'h40;
        step(1);
        chk("t1_req", {bif.bus_req, bif.sel, bif.bus_we}, 3'b100);
        chk("t1_addr", bif.bus_addr, 32'h40);
        chk("t1_stall", bif.if_stall, 1);
        bif.bus_ready = 1'b1;
        bif.bus_rdata = 32'h2402000A;
        step(1);
        chk("t1_done", {bif.if_done, bif.bus_req}, 2'b10);
        chk("t1_rdata", bif.if_rdata, 32'h2402000A);
        chk("t1_stall_done", bif.if_stall, 0);
        bif.bus_ready = 1'b0;
        bif.if_req    = 1'b0;
        step(1);
        chk("t1_pulse", bif.if_done, 0);
        chk("t1_hold", bif.if_rdata, 32'h2402000A);
        step(1);

        // 2: MEM beats IF, IF served afterwards
        bif.if_req    = 1'b1;
        bif.if_addr   = 32'h44;
        bif.mem_req   = 1'b1;
        bif.mem_we    = 1'b1;
        bif.mem_addr  = 32'h100;
        bif.mem_wdata = 32'hDEAD;
        step(1);
        chk("t2_mem", {bif.bus_req, bif.sel, bif.bus_we}, 3'b111);
        chk("t2_wdata", bif.bus_wdata, 32'hDEAD);
        chk("t2_addr", bif.bus_addr, 32'h100);
        bif.bus_ready = 1'b1;
        bif.bus_rdata = 32'h11111111;
        step(1);
        chk("t2_mdone", {bif.mem_done, bif.if_done, bif.bus_req}, 3'b100);
        chk("t2_mrdata", bif.mem_rdata, 32'h11111111);
        chk("t2_we_clr", bif.bus_we, 0);
        bif.mem_req   = 1'b0;
        bif.bus_ready = 1'b0;
        step(1);
        chk("t2_gap", bif.bus_req, 0);
        step(1);
        chk("t2_if", {bif.bus_req, bif.sel, bif.bus_we}, 3'b100);
        chk("t2_if_addr", bif.bus_addr, 32'h44);
        bif.bus_ready = 1'b1;
        bif.bus_rdata = 32'h8C220004;
        step(1);
        chk("t2_idone", {bif.if_done, bif.mem_done}, 2'b10);
        chk("t2_irdata", bif.if_rdata, 32'h8C220004);
        bif.if_req    = 1'b0;
        bif.bus_ready = 1'b0;
        step(2);

        // 3: both held high, memory always ready
        bif.if_req    = 1'b1;
        bif.if_addr   = 32'h80;
        bif.mem_req   = 1'b1;
        bif.mem_we    = 1'b0;
        bif.mem_addr  = 32'h200;
        bif.bus_ready = 1'b1;
        g = 0;
        for (int c = 0; c < 40; c++) begin
            step(1);
            if (bif.bus_req && g < 10) begin
                chk($sformatf("t3_grant%0d", g), bif.sel, exp_sel[g]);
                g++;
            end
        end
        chk("t3_ngrants", g, 10);
        bif.if_req  = 1'b0;
        bif.mem_req = 1'b0;
        step(2);
        bif.bus_ready = 1'b0;
        step(2);

        // 4: five wait states, then ready in IDLE
        bif.mem_req  = 1'b1;
        bif.mem_we   = 1'b0;
        bif.mem_addr = 32'h300;
        for (int c = 0; c < 6; c++) begin
            step(1);
            chk($sformatf("t4_hold%0d", c),
                {bif.bus_req, bif.mem_done, bif.bus_addr}, {2'b10, 32'h300});
            if (c == 5) begin
                bif.bus_ready = 1'b1;
                bif.bus_rdata = 32'h0BADF00D;
            end
        end
        step(1);
        chk("t4_done", {bif.mem_done, bif.bus_req}, 2'b10);
        chk("t4_rdata", bif.mem_rdata, 32'h0BADF00D);
        bif.mem_req = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step(1);
            chk($sformatf("t4_idle_rdy%0d", c),
                {bif.mem_done, bif.if_done, bif.bus_req}, 3'b000);
        end
        bif.bus_ready = 1'b0;
        step(1);

        // 5: MEM drops its request while busy
        bif.mem_req  = 1'b1;
        bif.mem_addr = 32'h400;
        step(1);
        chk("t5_busy", {bif.bus_req, bif.sel}, 2'b11);
        bif.mem_req = 1'b0;
        step(1);
        chk("t5_still", {bif.bus_req, bif.mem_stall}, 2'b10);
        bif.bus_ready = 1'b1;
        bif.bus_rdata = 32'hCAFEF00D;
        step(1);
        chk("t5_done", bif.mem_done, 1);
        chk("t5_rdata", bif.mem_rdata, 32'hCAFEF00D);
        bif.bus_ready = 1'b0;
        step(1);
        chk("t5_pulse", bif.mem_done, 0);
        step(1);

        // 6: reset in the middle of a store, IF waiting
        bif.mem_req   = 1'b1;
        bif.mem_we    = 1'b1;
        bif.mem_addr  = 32'h500;
        bif.mem_wdata = 32'hBEEF;
        bif.if_req    = 1'b1;
        bif.if_addr   = 32'h600;
        step(1);
        chk("t6_busy", {bif.bus_req, bif.sel, bif.bus_we}, 3'b111);
        #2;
        clrn = 1'b0;
        #1;
        chk("t6_rst_ctl", {bif.bus_req, bif.sel, bif.bus_we, bif.mem_done}, 0);
        chk("t6_rst_data", {bif.bus_addr, bif.bus_wdata}, 0);
        chk("t6_rst_rdata", bif.mem_rdata, 0);
        bif.mem_req = 1'b0;
        bif.mem_we  = 1'b0;
        step(1);
        clrn = 1'b1;
        chk("t6_no_done", bif.mem_done, 0);
        step(1);
        chk("t6_if", {bif.bus_req, bif.sel, bif.mem_done}, 3'b100);
        chk("t6_if_addr", bif.bus_addr, 32'h600);
        bif.bus_ready = 1'b1;
        bif.bus_rdata = 32'h600D;
        step(1);
        chk("t6_idone", {bif.if_done, bif.mem_done}, 2'b10);
        chk("t6_irdata", bif.if_rdata, 32'h600D);
        idle_inputs();
        step(2);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
